// File: rtl/tlul_sram_slave.sv
// TileLink-UL slave endpoint for a fixed-latency on-chip SRAM port.
// Accepts single-beat Get/PutFullData/PutPartialData and returns in-order D responses from a credit-guarded FIFO.
module tlul_sram_slave #(
  parameter int unsigned BW_ADDR        = 32,
  parameter int unsigned BW_DATA        = 32,
  parameter int unsigned BW_SIZE        = 2,
  parameter int unsigned BW_SOURCE      = 1,
  parameter int unsigned MEM_DEPTH_LOG2 = 10,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned RESP_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [2:0]                a_opcode,
  input  logic [2:0]                a_param,
  input  logic [BW_SIZE-1:0]        a_size,
  input  logic [BW_SOURCE-1:0]      a_source,
  input  logic [BW_ADDR-1:0]        a_address,
  input  logic [BW_DATA/8-1:0]      a_mask,
  input  logic [BW_DATA-1:0]        a_data,
  output logic                      d_valid,
  input  logic                      d_ready,
  output logic [2:0]                d_opcode,
  output logic [1:0]                d_param,
  output logic [BW_SIZE-1:0]        d_size,
  output logic [BW_SOURCE-1:0]      d_source,
  output logic                      d_sink,
  output logic                      d_denied,
  output logic [BW_DATA-1:0]        d_data,
  output logic                      d_corrupt,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_DEPTH_LOG2-1:0] mem_addr,
  output logic [BW_DATA/8-1:0]      mem_be,
  output logic [BW_DATA-1:0]        mem_wdata,
  input  logic [BW_DATA-1:0]        mem_rdata
);

  localparam int unsigned NB     = BW_DATA / 8;
  localparam int unsigned LANE_W = $clog2(NB);
  localparam int unsigned PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(RESP_DEPTH + 1);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  typedef struct packed {
    logic                 valid;
    logic                 is_get;
    logic                 denied;
    logic [BW_SIZE-1:0]   size;
    logic [BW_SOURCE-1:0] source;
  } stage_t;

  typedef struct packed {
    logic                 is_get;
    logic                 denied;
    logic [BW_SIZE-1:0]   size;
    logic [BW_SOURCE-1:0] source;
    logic [BW_DATA-1:0]   data;
  } resp_t;

  stage_t pipe_q [RD_LATENCY];
  stage_t pipe_d [RD_LATENCY];
  resp_t  fifo_q [RESP_DEPTH];
  resp_t  fifo_d [RESP_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, used_q, used_d;
  logic             a_ready_q, a_ready_d;

  logic          accept_c, is_get_c, op_ok_c, size_ok_c, align_ok_c, range_ok_c, mask_ok_c, denied_c;
  logic [31:0]   lane_off_c;
  logic [NB-1:0] full_mask_c;
  logic          push_c, pop_c;
  stage_t        tail_c;
  resp_t         head_c;

  logic unused_c;
  assign unused_c = ^a_param;

  // Request decode: legality checks and the combinational SRAM strobe.
  always_comb begin
    accept_c    = a_valid & a_ready_q;
    is_get_c    = (a_opcode == OP_GET);
    op_ok_c     = is_get_c | (a_opcode == OP_PUT_FULL) | (a_opcode == OP_PUT_PART);
    size_ok_c   = 32'(a_size) <= LANE_W;
    align_ok_c  = (a_address & ((BW_ADDR'(1) << a_size) - BW_ADDR'(1))) == '0;
    range_ok_c  = (a_address >> (MEM_DEPTH_LOG2 + LANE_W)) == '0;
    lane_off_c  = 32'(a_address & BW_ADDR'(NB - 1));
    full_mask_c = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i >= lane_off_c && i < lane_off_c + (32'd1 << a_size)) full_mask_c[i] = 1'b1;
    end
    mask_ok_c = (a_opcode != OP_PUT_FULL) || (a_mask == full_mask_c);
    denied_c  = !(op_ok_c & size_ok_c & align_ok_c & range_ok_c & mask_ok_c);

    mem_req   = accept_c & !denied_c;
    mem_we    = !is_get_c;
    mem_addr  = MEM_DEPTH_LOG2'(a_address >> LANE_W);
    mem_be    = is_get_c ? '1 : a_mask;
    mem_wdata = a_data;
  end

  // Latency-matching pipeline, FIFO push/pop and credit accounting.
  always_comb begin
    pipe_d[0] = '{valid: accept_c, is_get: is_get_c, denied: denied_c,
                  size: a_size, source: a_source};
    for (int unsigned i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];

    tail_c = pipe_q[RD_LATENCY-1];
    head_c = fifo_q[rd_ptr_q];
    push_c = tail_c.valid;
    pop_c  = (cnt_q != '0) & d_ready;

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) begin
      fifo_d[wr_ptr_q] = '{is_get: tail_c.is_get, denied: tail_c.denied,
                           size: tail_c.size, source: tail_c.source,
                           data: (tail_c.is_get && !tail_c.denied) ? mem_rdata : '0};
      wr_ptr_d = (wr_ptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    cnt_d     = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    used_d    = used_q + CNT_W'(accept_c) - CNT_W'(pop_c);
    a_ready_d = used_d < CNT_W'(RESP_DEPTH);
  end

  // D channel is driven from the FIFO head and zeroed while empty.
  always_comb begin
    a_ready   = a_ready_q;
    d_valid   = (cnt_q != '0);
    d_opcode  = (d_valid && head_c.is_get) ? ACK_DATA : ACK;
    d_param   = '0;
    d_sink    = 1'b0;
    d_size    = d_valid ? head_c.size : '0;
    d_source  = d_valid ? head_c.source : '0;
    d_denied  = d_valid & head_c.denied;
    d_corrupt = d_valid & head_c.denied & head_c.is_get;
    d_data    = d_valid ? head_c.data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
      for (int unsigned i = 0; i < RESP_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      used_q    <= '0;
      a_ready_q <= 1'b1;
    end else begin
      pipe_q    <= pipe_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      used_q    <= used_d;
      a_ready_q <= a_ready_d;
    end
  end

endmodule
